// File: rtl/mem_rr_sched.sv
// Purpose : round-robin share of one memory port among CNT requesters, with an in-order
//           tag FIFO that routes each response back to its issuer and per-requester flush.
// Latency : zero; request and response paths are combinational pass-through.
// Backpressure: mreq_ready_i low locks the current winner and address until the request fires;
//           a full tag FIFO holds mreq_valid_o low; responses stall on the owner's resp_ready_i.
// Ports   : clk_i/rst_i (async, active-low); req_*_i/o upstream request per requester
//           (address slice i = req_addr_i[i*AW +: AW]); resp_*_o/i per-requester response with
//           shared resp_data_o; flush_i per-requester discard pulse; mreq_*/mresp_* downstream.
// Option  : define MEM_SCHED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module mem_rr_sched #(
    parameter int CNT         = 2,
    parameter int OUTSTANDING = 4,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT-1:0]    req_valid_i,
    output logic [CNT-1:0]    req_ready_o,
    input  logic [CNT*AW-1:0] req_addr_i,
    output logic [CNT-1:0]    resp_valid_o,
    input  logic [CNT-1:0]    resp_ready_i,
    output logic [DW-1:0]     resp_data_o,
    input  logic [CNT-1:0]    flush_i,
    output logic              mreq_valid_o,
    input  logic              mreq_ready_i,
    output logic [AW-1:0]     mreq_addr_o,
    input  logic              mresp_valid_i,
    output logic              mresp_ready_o,
    input  logic [DW-1:0]     mresp_data_i
);

    localparam int IW = $clog2(CNT);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    // Arbitration state
    logic          lock_q, lock_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] arb_win;
    logic [IW-1:0] winner;
`ifndef MEM_SCHED_PRIO_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Tag FIFO: requester index plus a drop flag per in-flight transaction
    logic [IW-1:0]          idx_q [OUTSTANDING];
    logic [OUTSTANDING-1:0] drop_q;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] head_idx;
    logic          head_drop;

    // First requester with valid set, scanning upward from start with wrap.
    // A start of zero gives plain lowest-index priority.
    function automatic logic [IW-1:0] pick(input logic [CNT-1:0] v, input logic [IW-1:0] start);
        logic [IW-1:0] r;
        logic          found;
        int            j;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < CNT; k++) begin
            j = (int'(start) + k) % CNT;
            if (!found && v[j]) begin
                r     = IW'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign fifo_full  = (cnt_q == CW'(OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_idx   = idx_q[rd_ptr_q];
    assign head_drop  = drop_q[rd_ptr_q];

`ifdef MEM_SCHED_PRIO_EN
    assign arb_win = pick(req_valid_i, '0);
`else
    assign arb_win = pick(req_valid_i, rr_ptr_q);
`endif

    // A stalled request keeps its winner so address and grant stay stable until fire.
    assign winner = lock_q ? win_q : arb_win;

    // Outputs are gated by reset so they read zero the instant reset asserts.
    assign mreq_valid_o = rst_i & (|req_valid_i) & ~fifo_full;
    assign mreq_addr_o  = rst_i ? req_addr_i[int'(winner)*AW +: AW] : '0;
    assign push         = mreq_valid_o & mreq_ready_i;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < CNT; i++) begin
            req_ready_o[i] = push && (int'(winner) == i);
        end
    end

    // Response routing from the FIFO head; dropped entries are swallowed here.
    always_comb begin
        resp_valid_o  = '0;
        mresp_ready_o = 1'b0;
        resp_data_o   = rst_i ? mresp_data_i : '0;
        if (!fifo_empty) begin
            if (head_drop) begin
                mresp_ready_o = 1'b1;
            end else begin
                resp_valid_o[head_idx] = mresp_valid_i;
                mresp_ready_o          = resp_ready_i[head_idx];
            end
        end
    end

    assign pop = mresp_valid_i & mresp_ready_o;

    always_comb begin
        lock_d = lock_q;
        win_d  = win_q;
        if (push) begin
            lock_d = 1'b0;
        end else if (mreq_valid_o) begin
            lock_d = 1'b1;
            win_d  = winner;
        end
    end

`ifndef MEM_SCHED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (winner == IW'(CNT - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lock_q   <= 1'b0;
            win_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifndef MEM_SCHED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            lock_q   <= lock_d;
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
`ifndef MEM_SCHED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Flush marks every slot with a matching index; slots outside the live window are
    // harmless because a push always rewrites drop to zero. The push assignment comes
    // last so an entry written in the flush cycle is never dropped. The head's delivery
    // this cycle already used the pre-flush drop value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < OUTSTANDING; s++) begin
                idx_q[s] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int s = 0; s < OUTSTANDING; s++) begin
                if (flush_i[idx_q[s]]) begin
                    drop_q[s] <= 1'b1;
                end
            end
            if (push) begin
                idx_q[wr_ptr_q]  <= winner;
                drop_q[wr_ptr_q] <= 1'b0;
            end
        end
    end

    // A response with nothing in flight means the downstream broke protocol.
    a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(mresp_valid_i && fifo_empty));

endmodule

// File: tb/tb_mem_rr_sched.sv
module tb_mem_rr_sched;

    localparam int CNT = 2;
    localparam int OUT = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
`ifdef MEM_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [CNT-1:0]    req_valid, req_ready, resp_valid, resp_ready, flush;
    logic [CNT*AW-1:0] req_addr;
    logic [DW-1:0]     resp_data, mresp_data;
    logic              mreq_valid, mreq_ready, mresp_valid, mresp_ready;
    logic [AW-1:0]     mreq_addr;

    always #5 clk = ~clk;

    mem_rr_sched #(.CNT(CNT), .OUTSTANDING(OUT), .AW(AW), .DW(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .flush_i       (flush),
        .mreq_valid_o  (mreq_valid),
        .mreq_ready_i  (mreq_ready),
        .mreq_addr_o   (mreq_addr),
        .mresp_valid_i (mresp_valid),
        .mresp_ready_o (mresp_ready),
        .mresp_data_i  (mresp_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight transactions as a queue in issue order
    typedef struct { int idx; bit drop; } tag_t;
    tag_t          tq[$];
    logic [AW-1:0] mq[$];          // addresses the bench memory still owes a response for
    int            grant_log[$];
    int            rrp;
    bit            lk;
    int            lkw;
    logic [CNT-1:0] last_fire;
    bit            last_pop;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic model_clear();
        tq.delete();
        mq.delete();
        grant_log.delete();
        rrp       = 0;
        lk        = 1'b0;
        lkw       = 0;
        last_fire = '0;
        last_pop  = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        resp_ready  = '0;
        flush       = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
    endtask

    // Compare every DUT output against the model for the current inputs, then
    // advance the model to the state after the coming rising edge.
    task automatic eval_cycle();
        int             win, start;
        bit             found, mv, fire, pop;
        logic [CNT-1:0] e_rr, e_rv;
        logic           e_mr;
        tag_t           t;
        win   = 0;
        found = 1'b0;
        if (lk) begin
            win = lkw;
        end else begin
            start = PRIO ? 0 : rrp;
            for (int k = 0; k < CNT; k++) begin
                if (!found && req_valid[(start + k) % CNT]) begin
                    win   = (start + k) % CNT;
                    found = 1'b1;
                end
            end
        end
        mv   = (req_valid != '0) && (tq.size() < OUT);
        fire = mv && mreq_ready;
        e_rr = fire ? CNT'(1 << win) : '0;
        chk("mreq_valid", mreq_valid, mv);
        if (mv) chk("mreq_addr", mreq_addr, req_addr[win*AW +: AW]);
        chk("req_ready", req_ready, e_rr);

        e_rv = '0;
        e_mr = 1'b0;
        if (tq.size() > 0) begin
            if (tq[0].drop) begin
                e_mr = 1'b1;
            end else begin
                e_rv = mresp_valid ? CNT'(1 << tq[0].idx) : '0;
                e_mr = resp_ready[tq[0].idx];
            end
        end
        chk("resp_valid", resp_valid, e_rv);
        chk("mresp_ready", mresp_ready, e_mr);
        if (e_rv != '0) chk("resp_data", resp_data, mresp_data);
        pop = mresp_valid && e_mr;

        if (pop) begin
            void'(tq.pop_front());
            void'(mq.pop_front());
        end
        for (int k = 0; k < tq.size(); k++) begin
            if (flush[tq[k].idx]) begin
                t      = tq[k];
                t.drop = 1'b1;
                tq[k]  = t;
            end
        end
        if (fire) begin
            tq.push_back('{win, 1'b0});
            mq.push_back(req_addr[win*AW +: AW]);
            grant_log.push_back(win);
            rrp = (win + 1) % CNT;
            lk  = 1'b0;
        end else if (mv) begin
            lk  = 1'b1;
            lkw = win;
        end
        last_fire = e_rr;
        last_pop  = pop;
    endtask

    task automatic settle();
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        adv();
    endtask

    // Return every outstanding response with all requesters ready.
    task automatic drain(input int n);
        req_valid  = '0;
        resp_ready = '1;
        for (int c = 0; c < n; c++) begin
            if (mq.size() > 0) begin
                mresp_valid = 1'b1;
                mresp_data  = mdata(mq[0]);
                settle();
                adv();
            end
        end
        mresp_valid = 1'b0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < CNT; i++) begin
            // A pending request holds valid and address until it fires
            if (!(req_valid[i] && !last_fire[i])) begin
                req_valid[i] = ($urandom_range(0, 99) < 55);
                set_addr(i, $urandom() & 32'hFFFF_FFFC);
            end
            resp_ready[i] = ($urandom_range(0, 99) < 75);
            flush[i]      = ($urandom_range(0, 99) < 6);
        end
        mreq_ready = ($urandom_range(0, 99) < 65);
        if (mq.size() == 0) begin
            mresp_valid = 1'b0;
        end else if (!(mresp_valid && !last_pop)) begin
            mresp_valid = ($urandom_range(0, 99) < 70);
        end
        mresp_data = mresp_valid ? mdata(mq[0]) : DW'($urandom());
    endtask

    initial begin
        logic [CNT-1:0] exp_g;
        rst      = 1'b1;
        req_addr = '0;
        idle_inputs();
        model_clear();

        // Reset values with requests already pending
        #1;
        rst        = 1'b0;
        req_valid  = '1;
        resp_ready = '1;
        set_addr(0, 32'h1234_5678);
        set_addr(1, 32'h9ABC_DEF0);
        mresp_data = 32'hFFFF_FFFF;
        #2;
        chk("rst_mreq_valid", mreq_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_mresp_ready", mresp_ready, 1'b0);
        chk("rst_mreq_addr", mreq_addr, '0);
        chk("rst_resp_data", resp_data, '0);
        do_reset();

        // Single requester, two requests, in-order responses
        mreq_ready = 1'b1;
        req_valid  = 2'b01;
        set_addr(0, 32'h8000_0000);
        settle();
        chk("sr_grant0", req_ready, 2'b01);
        chk("sr_addr0", mreq_addr, 32'h8000_0000);
        adv();
        set_addr(0, 32'h8000_0004);
        settle();
        chk("sr_addr1", mreq_addr, 32'h8000_0004);
        adv();
        req_valid   = '0;
        resp_ready  = 2'b01;
        mresp_valid = 1'b1;
        mresp_data  = 32'h11;
        settle();
        chk("sr_rv0", resp_valid, 2'b01);
        chk("sr_data0", resp_data, 32'h11);
        adv();
        mresp_data = 32'h22;
        settle();
        chk("sr_rv1", resp_valid, 2'b01);
        chk("sr_data1", resp_data, 32'h22);
        adv();
        mresp_valid = 1'b0;
        settle();
        chk("sr_idle", resp_valid, '0);
        adv();

        // Round-robin alternation with both requesters always valid
        do_reset();
        mreq_ready = 1'b1;
        req_valid  = 2'b11;
        for (int c = 0; c < 4; c++) begin
            set_addr(0, 32'h1000 + 8 * c);
            set_addr(1, 32'h2000 + 8 * c);
            settle();
            exp_g = (PRIO || (c % 2 == 0)) ? 2'b01 : 2'b10;
            chk("rr_grant", req_ready, exp_g);
            adv();
        end
        drain(4);

        // Backpressure: the winner and its address hold until fire
        do_reset();
        set_addr(0, 32'h0000_2000);
        set_addr(1, 32'h0000_3000);
        req_valid = 2'b10;
        settle();
        chk("bp_valid", mreq_valid, 1'b1);
        chk("bp_addr_a", mreq_addr, 32'h3000);
        adv();
        req_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("bp_addr_hold", mreq_addr, 32'h3000);
            chk("bp_no_grant", req_ready, '0);
            adv();
        end
        mreq_ready = 1'b1;
        settle();
        chk("bp_fire", req_ready, 2'b10);
        adv();
        settle();
        chk("bp_next", req_ready, 2'b01);
        chk("bp_next_addr", mreq_addr, 32'h2000);
        adv();
        drain(2);

        // Full FIFO blocks the fifth request; a pop reopens it only on the next cycle
        do_reset();
        mreq_ready = 1'b1;
        req_valid  = 2'b01;
        for (int c = 0; c < 4; c++) begin
            set_addr(0, 32'h4000 + 4 * c);
            settle();
            chk("full_fire", req_ready, 2'b01);
            adv();
        end
        set_addr(0, 32'h4010);
        settle();
        chk("full_block", mreq_valid, 1'b0);
        adv();
        mresp_valid = 1'b1;
        resp_ready  = 2'b01;
        mresp_data  = 32'h55;
        settle();
        chk("full_pop_same", mreq_valid, 1'b0);
        chk("full_pop_rdy", mresp_ready, 1'b1);
        adv();
        mresp_valid = 1'b0;
        settle();
        chk("full_reopen", mreq_valid, 1'b1);
        chk("full_reopen_grant", req_ready, 2'b01);
        adv();
        drain(4);

        // Flush requester 0 with requests 0,1,0 in flight
        do_reset();
        mreq_ready = 1'b1;
        req_valid  = 2'b01; set_addr(0, 32'h5000); settle(); adv();
        req_valid  = 2'b10; set_addr(1, 32'h5100); settle(); adv();
        req_valid  = 2'b01; set_addr(0, 32'h5200); settle(); adv();
        req_valid  = '0;
        flush      = 2'b01;
        settle();
        adv();
        flush       = '0;
        resp_ready  = 2'b11;
        mresp_valid = 1'b1;
        mresp_data  = 32'hA1;
        settle();
        chk("fl_drop0_rdy", mresp_ready, 1'b1);
        chk("fl_drop0_rv", resp_valid, '0);
        adv();
        mresp_data = 32'hB2;
        settle();
        chk("fl_keep_rv", resp_valid, 2'b10);
        chk("fl_keep_data", resp_data, 32'hB2);
        adv();
        mresp_data = 32'hC3;
        settle();
        chk("fl_drop2_rdy", mresp_ready, 1'b1);
        chk("fl_drop2_rv", resp_valid, '0);
        adv();
        mresp_valid = 1'b0;
        settle();
        chk("fl_empty_rdy", mresp_ready, 1'b0);
        adv();

        // Asynchronous reset mid-cycle with two transactions outstanding
        do_reset();
        mreq_ready = 1'b1;
        req_valid  = 2'b11;
        set_addr(0, 32'h6000);
        set_addr(1, 32'h6100);
        settle(); adv();
        settle(); adv();
        mreq_ready = 1'b0;
        resp_ready = 2'b11;
        settle();
        chk("ar_pre_rdy", mresp_ready, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mreq_valid", mreq_valid, 1'b0);
        chk("ar_mresp_ready", mresp_ready, 1'b0);
        chk("ar_req_ready", req_ready, '0);
        chk("ar_resp_valid", resp_valid, '0);
        chk("ar_mreq_addr", mreq_addr, '0);
        idle_inputs();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        adv();
        mreq_ready = 1'b1;
        req_valid  = 2'b10;
        set_addr(1, 32'h9000_0010);
        settle();
        chk("ar_fresh_grant", req_ready, 2'b10);
        chk("ar_fresh_addr", mreq_addr, 32'h9000_0010);
        adv();
        req_valid   = '0;
        resp_ready  = 2'b11;
        mresp_valid = 1'b1;
        mresp_data  = 32'h77;
        settle();
        chk("ar_fresh_rv", resp_valid, 2'b10);
        chk("ar_fresh_data", resp_data, 32'h77);
        adv();
        mresp_valid = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            settle();
            adv();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rr_sched.md
Name: mem_rr_sched

Overview:
- Shares the single CPU memory port among CNT requesters: instruction fetch (index 0), load/store (index 1), and later a page walker.
- Arbitrates requests round-robin and records the granted requester index in an in-order tag FIFO.
- Routes each memory response back to the requester that issued the matching request.
- Supports a per-requester flush that discards that requester's in-flight responses. Sits between the stages and the top-level mem_req/mem_resp decoupled pair.

Parameters:
- CNT, 2: number of requesters, 2..8.
- OUTSTANDING, 4: tag FIFO depth, i.e. the maximum number of in-flight transactions; power of 2, at least 2.
- AW, 32: address width.
- DW, 32: response data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  CNT  per-requester request valid.
- req_ready  out  CNT  per-requester request accepted.
- req_addr  in  CNT*AW  per-requester address; slice i is bits [i*AW +: AW].
- resp_valid  out  CNT  per-requester response valid.
- resp_ready  in  CNT  per-requester response ready.
- resp_data  out  DW  response data, shared by all requesters; qualified by resp_valid[i].
- flush  in  CNT  one-cycle pulse per requester: discard that requester's outstanding responses.
- mreq_valid  out  1  downstream request valid.
- mreq_ready  in  1  downstream request ready.
- mreq_addr  out  AW  downstream address.
- mresp_valid  in  1  downstream response valid.
- mresp_ready  out  1  downstream response ready.
- mresp_data  in  DW  downstream response data.

Behaviour:
- Reset (rst=0, async) values:
  - rr_ptr = 0; FIFO empty; all drop bits cleared; lock = 0.
  - All outputs 0, except resp_data and mreq_addr, which are don't-care and driven to 0.
- Reset mid-transaction: all in-flight tags are lost. Downstream is reset by the same rst; no recovery is required.
- Grant:
  - When lock = 0, winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo CNT.
  - mreq_valid = any req_valid & !fifo_full.
  - mreq_addr = req_addr of the winner.
  - req_ready[i] = mreq_ready & mreq_valid & (i == winner). Purely combinational path, zero added latency.
- Lock:
  - If mreq_valid=1 and mreq_ready=0, set lock = 1 and hold the winner in a register. The winner and address must not change until the request fires. This is decoupled stability.
  - Clear lock on fire.
- Fire (mreq_valid & mreq_ready):
  - Push {winner, drop=0} into the FIFO.
  - rr_ptr <= (winner+1) mod CNT.
  - rr_ptr does not advance without a fire.
- Full:
  - fifo_full blocks mreq_valid, even if a pop happens in the same cycle. There is no bypass.
  - If full occurs while locked, mreq_valid deasserts. This cannot happen because push only occurs on fire, and the lock is set only while valid; full is checked before valid.
- Response:
  - head = FIFO head entry.
  - If the FIFO is empty: mresp_ready = 0 and all resp_valid = 0. Any mresp_valid in that state is a protocol error; flag it with an assertion.
  - If head.drop = 0:
    - resp_valid[head.idx] = mresp_valid.
    - resp_data = mresp_data.
    - mresp_ready = resp_ready[head.idx].
  - If head.drop = 1: mresp_ready = 1, all resp_valid = 0, and the response is silently consumed.
  - Pop on mresp_valid & mresp_ready.
  - Combinational pass-through, zero latency. Responses are strictly in order.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged. Pointers wrap modulo OUTSTANDING.
- Flush:
  - In the flush cycle, set drop on every valid entry whose idx matches a flushed i, including the head.
  - A head popped in that same cycle is still delivered if its drop was 0 at the start of the cycle.
  - An entry pushed in the flush cycle is not dropped.
  - Flush does not cancel a locked, not-yet-fired request. The requester is responsible for deasserting valid only after it fires.

Optional Feature:
- MEM_SCHED_PRIO_EN
- Defined: fixed priority replaces round-robin. The winner is the lowest index with req_valid set; rr_ptr is removed; lock and stability rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single requester: req0 sends addrs 0x80000000 and 0x80000004 with mreq_ready=1 and in-order responses 0x11, 0x22 -> resp_valid[0] pulses twice with data 0x11, 0x22; resp_valid[1] stays 0.
- Round-robin: req0 and req1 valid continuously with mreq_ready=1 -> grants alternate 0,1,0,1. With MEM_SCHED_PRIO_EN, the grant is always 0.
- Backpressure stability: both requesters valid, mreq_ready=0 for 3 cycles -> mreq_addr and winner stay constant; rr_ptr stays unchanged until fire.
- Full: OUTSTANDING=4, four fires with no responses -> mreq_valid=0 on the fifth request. One response pop -> mreq_valid=1 the next cycle, not the same cycle.
- Flush: requests 0,1,0 outstanding, then flush[0] pulse -> the three responses are consumed with mresp_ready=1; only the middle response appears on resp_valid[1].
- Async reset: assert rst=0 mid-cycle with two transactions outstanding -> outputs go to 0 immediately. After release, a fresh req1 is granted and its response is routed correctly.
